// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller: opcodes,
// forward-select encodings, per-stage shadow record and FSM states.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Register-usage summary carried alongside each instruction in the pipe
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       regwen;
        logic       is_load;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                        uses_rs1: 1'b0, uses_rs2: 1'b0,
                                        regwen: 1'b0, is_load: 1'b0};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    // Operand source for one EX source register; MEM wins over WB because
    // it holds the younger result. Loads in MEM have no data yet.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       uses,
                                           input stage_t     mem,
                                           input stage_t     wb);
        logic [1:0] sel;
        if (uses && mem.regwen && !mem.is_load && (mem.rd == rs)) begin
            sel = FWD_MEM;
        end else if (uses && wb.regwen && (wb.rd == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_hz_field_decode.sv
// Combinational decode of the ID-stage instruction into the register-usage
// record tracked by the hazard controller. A bubble decodes to all zeros.
module hz_field_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output stage_t      fields
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    // Extract source/destination registers and classify the opcode
    always_comb begin
        fields = STAGE_BUBBLE;
        if (valid) begin
            fields.rs1      = instr[19:15];
            fields.rs2      = instr[24:20];
            fields.rd       = instr[11:7];
            fields.uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
            fields.uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
            fields.regwen   = (opcode != OP_S) && (opcode != OP_B) && (instr[11:7] != 5'd0);
            fields.is_load  = (opcode == OP_LOAD);
        end else begin
            fields = STAGE_BUBBLE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: memory-wait freeze,
// branch flush, load-use stall, operand forwarding and a stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_pcsel,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_t id_fields;
    stage_t ex_r;
    stage_t mem_r;
    stage_t wb_r;
    state_t state_r;
    logic   freeze;
    logic   load_use;

    hz_field_decode u_decode (
        .instr  (id_instr),
        .valid  (id_valid),
        .fields (id_fields)
    );

    // Freeze while memory is outstanding; the completing cycle advances
    always_comb begin
        freeze = 1'b0;
        case (state_r)
            ST_RUN:   freeze = dmem_req && !dmem_ready;
            ST_MWAIT: freeze = !dmem_ready;
            default:  freeze = 1'b0;
        endcase
    end

    // Load in EX whose destination is read by the real instruction in ID
    always_comb begin
        load_use = 1'b0;
        if (ex_r.is_load && (ex_r.rd != 5'd0) && id_valid) begin
            load_use = (id_fields.uses_rs1 && (id_fields.rs1 == ex_r.rd)) ||
                       (id_fields.uses_rs2 && (id_fields.rs2 == ex_r.rd));
        end else begin
            load_use = 1'b0;
        end
    end

    // Pipeline enables and flushes: freeze, then redirect, then load-use
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_en    = 1'b1;
        if (freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
        end else if (ex_pcsel) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    // Forward selects follow the shadow stages regardless of freeze
    always_comb begin
        fwd_a = fwd_sel(ex_r.rs1, ex_r.uses_rs1, mem_r, wb_r);
        fwd_b = fwd_sel(ex_r.rs2, ex_r.uses_rs2, mem_r, wb_r);
    end

    // Memory-wait state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN:   state_r <= (dmem_req && !dmem_ready) ? ST_MWAIT : ST_RUN;
                ST_MWAIT: state_r <= dmem_ready ? ST_RUN : ST_MWAIT;
                default:  state_r <= ST_RUN;
            endcase
        end
    end

    // Shadow EX/MEM/WB register-usage records advance with the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r  <= STAGE_BUBBLE;
            mem_r <= STAGE_BUBBLE;
            wb_r  <= STAGE_BUBBLE;
        end else if (!freeze) begin
            ex_r  <= idex_flush ? STAGE_BUBBLE : id_fields;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end else begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expectations are queued as
// stimulus is applied and compared against the DUT outputs mid-cycle.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_pcsel;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pipe_en;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_cnt;

    // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en}
    localparam logic [4:0] C_RUN = 5'b11001;
    localparam logic [4:0] C_FRZ = 5'b00000;
    localparam logic [4:0] C_FLS = 5'b11111;
    localparam logic [4:0] C_LU  = 5'b00011;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [4:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .ex_pcsel   (ex_pcsel),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .pipe_en    (pipe_en),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare against the live outputs
    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_ctl"}, {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, pipe_en},
                     {27'd0, e.ctl});
            check_eq({tag, "_fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
            check_eq({tag, "_fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
            check_eq({tag, "_cnt"}, stall_cnt, e.cnt);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check before the edge
    task automatic step(input string tag, input logic [31:0] instr, input logic valid,
                        input logic pcsel, input logic req, input logic rdy,
                        input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] cnt);
        @(negedge clk);
        id_instr   = instr;
        id_valid   = valid;
        ex_pcsel   = pcsel;
        dmem_req   = req;
        dmem_ready = rdy;
        exp_q.push_back('{ctl: ctl, fa: fa, fb: fb, cnt: cnt});
        #2;
        compare_outputs(tag);
    endtask

    initial begin
        rst        = 1'b1;
        id_instr   = NOP;
        id_valid   = 1'b0;
        ex_pcsel   = 1'b0;
        dmem_req   = 1'b0;
        dmem_ready = 1'b0;
        exp_q.push_back('{ctl: C_RUN, fa: 2'b00, fb: 2'b00, cnt: 32'd0});
        #1;
        compare_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // forward from EX/MEM
        step("t1_s1", enc_r(5'd1, 5'd2, 5'd3, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t1_s2", enc_r(5'd4, 5'd1, 5'd5, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t1_fwd", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b01, 2'b00, 32'd0);
        // forward from WB, and no forward for x0
        step("t2_s1", enc_r(5'd1, 5'd8, 5'd9, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t2_s2", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t2_s3", enc_r(5'd6, 5'd7, 5'd1, 7'h20), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t2_wb", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b10, 32'd0);
        step("t2_x0a", enc_r(5'd0, 5'd10, 5'd11, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t2_x0b", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t2_x0c", enc_r(5'd12, 5'd13, 5'd0, 7'h20), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t2_x0", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        // MEM beats WB when both write the same register
        step("pr_s1", enc_r(5'd5, 5'd1, 5'd1, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("pr_s2", enc_r(5'd5, 5'd2, 5'd2, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("pr_s3", enc_r(5'd7, 5'd5, 5'd5, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("pr_fwd", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b01, 2'b01, 32'd0);
        // load-use: one bubble, then WB forward
        step("t3_lw", enc_lw(5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);
        step("t3_stall", enc_r(5'd3, 5'd1, 5'd1, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 2'b00, 2'b00, 32'd0);
        step("t3_retry", enc_r(5'd3, 5'd1, 5'd1, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        step("t3_fwd", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b10, 2'b10, 32'd1);
        // taken branch overrides load-use
        step("t4_lw", enc_lw(5'd2, 5'd4), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        step("t4_br", enc_r(5'd9, 5'd2, 5'd0, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0, C_FLS, 2'b00, 2'b00, 32'd1);
        step("t4_after", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        // invalid ID instruction never stalls
        step("iv_lw", enc_lw(5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        step("iv_bub", enc_r(5'd1, 5'd8, 5'd8, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        // store with memory wait, branch held off until completion
        step("t5_sw", enc_sw(5'd5, 5'd6), 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        step("t5_nop", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd1);
        step("t5_w1", enc_r(5'd11, 5'd12, 5'd13, 7'd0), 1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00, 32'd1);
        step("t5_w2", enc_r(5'd11, 5'd12, 5'd13, 7'd0), 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00, 32'd2);
        step("t5_w3", enc_r(5'd11, 5'd12, 5'd13, 7'd0), 1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00, 32'd3);
        step("t5_done", enc_r(5'd11, 5'd12, 5'd13, 7'd0), 1'b1, 1'b1, 1'b1, 1'b1, C_FLS, 2'b00, 2'b00, 32'd4);
        step("t5_run", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd4);
        // reset in the middle of a memory wait
        step("t6_w1", enc_r(5'd1, 5'd2, 5'd3, 7'd0), 1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00, 32'd4);
        step("t6_w2", enc_r(5'd1, 5'd2, 5'd3, 7'd0), 1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00, 32'd5);
        @(negedge clk);
        id_instr   = NOP;
        id_valid   = 1'b0;
        ex_pcsel   = 1'b0;
        dmem_req   = 1'b0;
        dmem_ready = 1'b0;
        rst        = 1'b1;
        exp_q.push_back('{ctl: C_RUN, fa: 2'b00, fb: 2'b00, cnt: 32'd0});
        #1;
        compare_outputs("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        // ready low with no request: only a RUN state stays unfrozen
        step("t6_run", NOP, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule
